// File: rtl/clk_meas_pkg.sv
// Shared types, default parameters and helpers for the clock period meter.
package clk_meas_pkg;

    localparam int unsigned DEF_CNT_W         = 25;
    localparam int unsigned DEF_EXPECT_PERIOD = 4;
    localparam int unsigned DEF_TOL           = 0;
    localparam int unsigned DEF_LOCK_N        = 3;
    localparam int unsigned DEF_TIMEOUT       = 64;

    // Lock counter only needs to reach LOCK_N (at most 15).
    localparam int unsigned MATCH_W = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meas_state_e;

    // Absolute deviation of a measured period from nominal, computed without wrap.
    function automatic logic period_match(input logic [31:0] cnt,
                                          input logic [31:0] nominal,
                                          input logic [31:0] tol);
        logic [31:0] diff;
        diff = (cnt >= nominal) ? (cnt - nominal) : (nominal - cnt);
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with a history flop for rising-edge detection.
module sync_edge_det (
    input  logic clkin,
    input  logic rstn,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // Shift the asynchronous input through the synchroniser and history stage.
    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchroniser and history registers.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow clock in fast-clock cycles, tracks lock and loss of toggling.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned EXPECT_PERIOD = DEF_EXPECT_PERIOD,
    parameter int unsigned TOL           = DEF_TOL,
    parameter int unsigned LOCK_N        = DEF_LOCK_N,
    parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
    input  logic             clkin,
    input  logic             rstn,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   ONE_C     = CNT_W'(1);
    localparam logic [MATCH_W-1:0] LOCK_C    = MATCH_W'(LOCK_N);

    logic                level;
    logic                rise;
    logic                at_limit;
    logic                in_tol;

    meas_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    hcnt_q, hcnt_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic [CNT_W-1:0]    high_time_q, high_time_d;
    logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
    logic                period_valid_q, period_valid_d;
    logic                locked_q, locked_d;
    logic                timeout_q, timeout_d;

    sync_edge_det u_sync (
        .clkin    (clkin),
        .rstn     (rstn),
        .async_in (sig_in),
        .level    (level),
        .rise     (rise)
    );

    // Timeout is only raised when no edge arrives in the cycle the count saturates.
    assign at_limit = (cnt_q == TIMEOUT_C) && !rise;
    assign in_tol   = period_match(32'(cnt_q), 32'(EXPECT_PERIOD), 32'(TOL));

    // Period and high-time counters, restarted on every edge and saturating at the timeout.
    always_comb begin
        cnt_d  = cnt_q;
        hcnt_d = hcnt_q;
        if (rise) begin
            cnt_d  = ONE_C;
            hcnt_d = ONE_C;
        end else begin
            if (cnt_q != TIMEOUT_C) begin
                cnt_d = cnt_q + ONE_C;
            end
            if (level && (hcnt_q != TIMEOUT_C)) begin
                hcnt_d = hcnt_q + ONE_C;
            end
        end
    end

    // Measurement FSM: next state, period report, lock tracking and timeout.
    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        high_time_d    = high_time_q;
        match_cnt_d    = match_cnt_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        timeout_d      = timeout_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                end else if (at_limit) begin
                    timeout_d = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d       = cnt_q;
                    high_time_d    = hcnt_q;
                    period_valid_d = 1'b1;
                    if (in_tol) begin
                        match_cnt_d = (match_cnt_q >= LOCK_C) ? LOCK_C
                                                              : match_cnt_q + MATCH_W'(1);
                        locked_d    = (match_cnt_d == LOCK_C);
                    end else begin
                        match_cnt_d = '0;
                        locked_d    = 1'b0;
                    end
                end else if (at_limit) begin
                    timeout_d   = 1'b1;
                    locked_d    = 1'b0;
                    match_cnt_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            hcnt_q         <= '0;
            period_q       <= '0;
            high_time_q    <= '0;
            match_cnt_q    <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hcnt_q         <= hcnt_d;
            period_q       <= period_d;
            high_time_q    <= high_time_d;
            match_cnt_q    <= match_cnt_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: event-level reference model over sig_in waveforms.
module tb_clk_period_meter;

    localparam int unsigned CNT_W = 25;
    localparam int          EXP_P = 4;
    localparam int          TOUT  = 64;
    localparam int          LOCKN = 3;
    localparam int          MAXN  = 700;

    logic             clkin = 1'b0;
    logic             rstn;
    logic             sig_in;
    logic [CNT_W-1:0] period0, high0, period1, high1;
    logic             pv0, lk0, to0, pv1, lk1, to1;

    int n_checks = 0;
    int n_errors = 0;

    // Waveform: samp[e] is the sig_in level captured at clock edge e after reset release.
    int samp [0:MAXN];
    int nsamp = 0;

    // Expected outputs after each edge, per DUT (0: TOL=0, 1: TOL=1).
    int exp_pv  [2][0:MAXN];
    int exp_per [2][0:MAXN];
    int exp_ht  [2][0:MAXN];
    int exp_lk  [2][0:MAXN];
    int exp_to  [2][0:MAXN];

    always #5 clkin = ~clkin;

    clk_period_meter u_dut0 (
        .clkin        (clkin),
        .rstn         (rstn),
        .sig_in       (sig_in),
        .period       (period0),
        .high_time    (high0),
        .period_valid (pv0),
        .locked       (lk0),
        .timeout      (to0)
    );

    clk_period_meter #(.TOL(1)) u_dut1 (
        .clkin        (clkin),
        .rstn         (rstn),
        .sig_in       (sig_in),
        .period       (period1),
        .high_time    (high1),
        .period_valid (pv1),
        .locked       (lk1),
        .timeout      (to1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp_v);
        end
    endtask

    task automatic add_level(input int v, input int len);
        for (int i = 0; i < len; i++) begin
            nsamp++;
            samp[nsamp] = v;
        end
    endtask

    task automatic add_period(input int p, input int h);
        add_level(1, h);
        add_level(0, p - h);
    endtask

    // Reference model: periods are distances between rising samples; reports land two edges later.
    task automatic build_model();
        samp[0] = 0;
        for (int d = 0; d < 2; d++) begin
            int  tol, per, ht, to, lk, mc, last_n, last_e, pv, n;
            bit  meas, is_rise;
            tol = (d == 0) ? 0 : 1;
            per = 0; ht = 0; to = 0; lk = 0; mc = 0; last_n = 0; last_e = 0;
            meas = 1'b0;
            for (int e = 1; e <= nsamp; e++) begin
                n = e - 2;
                pv = 0;
                is_rise = 1'b0;
                if (n >= 1) is_rise = (samp[n] == 1) && ((n == 1) || (samp[n-1] == 0));
                if (is_rise) begin
                    if (meas) begin
                        int gap, ones, dev;
                        gap  = n - last_n;
                        ones = 0;
                        for (int i = last_n; i < n; i++) ones += samp[i];
                        per = gap;
                        ht  = ones;
                        pv  = 1;
                        dev = (gap > EXP_P) ? gap - EXP_P : EXP_P - gap;
                        if (dev <= tol) begin
                            mc = (mc < LOCKN) ? mc + 1 : LOCKN;
                            lk = (mc == LOCKN) ? 1 : 0;
                        end else begin
                            mc = 0;
                            lk = 0;
                        end
                    end else begin
                        meas = 1'b1;
                        to   = 0;
                    end
                    last_n = n;
                    last_e = e;
                end else if (meas && (e == last_e + TOUT)) begin
                    to = 1; lk = 0; mc = 0;
                    meas = 1'b0;
                end else if (!meas && (last_e == 0) && (e == TOUT + 1)) begin
                    to = 1;
                end
                exp_pv[d][e]  = pv;
                exp_per[d][e] = per;
                exp_ht[d][e]  = ht;
                exp_lk[d][e]  = lk;
                exp_to[d][e]  = to;
            end
        end
    endtask

    task automatic check_cycle(input int e);
        check_eq("pv0",     32'(pv0),     32'(exp_pv[0][e]));
        check_eq("period0", 32'(period0), 32'(exp_per[0][e]));
        check_eq("high0",   32'(high0),   32'(exp_ht[0][e]));
        check_eq("locked0", 32'(lk0),     32'(exp_lk[0][e]));
        check_eq("tmo0",    32'(to0),     32'(exp_to[0][e]));
        check_eq("pv1",     32'(pv1),     32'(exp_pv[1][e]));
        check_eq("period1", 32'(period1), 32'(exp_per[1][e]));
        check_eq("high1",   32'(high1),   32'(exp_ht[1][e]));
        check_eq("locked1", 32'(lk1),     32'(exp_lk[1][e]));
        check_eq("tmo1",    32'(to1),     32'(exp_to[1][e]));
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_pv"},  32'({pv0, pv1}),   32'(0));
        check_eq({tag, "_per"}, 32'(period0 | period1), 32'(0));
        check_eq({tag, "_ht"},  32'(high0 | high1), 32'(0));
        check_eq({tag, "_lk"},  32'({lk0, lk1}),   32'(0));
        check_eq({tag, "_to"},  32'({to0, to1}),   32'(0));
    endtask

    // Reset, play the waveform edge by edge, then assert reset mid-cycle and check outputs clear at once.
    task automatic run_segment();
        build_model();
        rstn   = 1'b0;
        sig_in = 1'b0;
        @(posedge clkin);
        #1;
        check_zero("rst");
        @(negedge clkin);
        rstn   = 1'b1;
        sig_in = samp[1][0];
        for (int e = 1; e <= nsamp; e++) begin
            @(posedge clkin);
            #1;
            check_cycle(e);
            if (e < nsamp) begin
                @(negedge clkin);
                sig_in = samp[e+1][0];
            end
        end
        #2;
        rstn = 1'b0;
        #1;
        check_zero("async_rst");
        nsamp = 0;
    endtask

    initial begin
        rstn   = 1'b0;
        sig_in = 1'b0;

        // Nominal 2/2 square wave, one stretched 3/3 period, then relock.
        add_level(0, 3);
        for (int i = 0; i < 6; i++) add_period(4, 2);
        add_period(6, 3);
        for (int i = 0; i < 5; i++) add_period(4, 2);
        run_segment();

        // Periods 3,5,4 (in tolerance only for TOL=1), then loss of toggling and recovery.
        add_level(0, 2);
        for (int i = 0; i < 4; i++) begin
            add_period(3, 1);
            add_period(5, 2);
            add_period(4, 2);
        end
        add_level(0, 80);
        for (int i = 0; i < 3; i++) add_period(4, 2);
        run_segment();

        // Held high from reset.
        add_level(1, 90);
        run_segment();

        // Timeout boundary: a period of exactly TIMEOUT is reported, one more times out.
        add_level(0, 2);
        for (int i = 0; i < 4; i++) add_period(4, 2);
        add_period(TOUT, 30);
        add_period(TOUT + 1, 30);
        for (int i = 0; i < 5; i++) add_period(4, 2);
        run_segment();

        // Locked, then reset mid-period; next segment must need two edges before reporting.
        add_level(0, 1);
        for (int i = 0; i < 6; i++) add_period(4, 2);
        add_level(1, 1);
        run_segment();
        for (int i = 0; i < 5; i++) add_period(4, 2);
        run_segment();

        // Randomised mixes of periods, duty cycles and stalls.
        for (int s = 0; s < 6; s++) begin
            add_level(0, int'($urandom_range(0, 5)));
            while (nsamp < 350) begin
                int r, p, h;
                r = int'($urandom_range(0, 99));
                if (r < 6) begin
                    add_level(int'($urandom_range(0, 1)), int'($urandom_range(60, 80)));
                end else begin
                    p = (r < 60) ? 4 : int'($urandom_range(2, 9));
                    h = int'($urandom_range(1, p - 1));
                    add_period(p, h);
                end
            end
            run_segment();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
